// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter datapath: command encoding,
// stack-pointer sizing helper and the default address type.
package cpu_pkg;

  // Command selected on each edge, listed from highest to lowest priority.
  localparam logic [2:0] CMD_RESET  = 3'd0;
  localparam logic [2:0] CMD_LOAD   = 3'd1;
  localparam logic [2:0] CMD_BRANCH = 3'd2;
  localparam logic [2:0] CMD_CALL   = 3'd3;
  localparam logic [2:0] CMD_RET    = 3'd4;
  localparam logic [2:0] CMD_INC    = 3'd5;
  localparam logic [2:0] CMD_HOLD   = 3'd6;

  // Default datapath address width and its type.
  localparam int ADDR_W = 16;
  typedef logic [ADDR_W-1:0] addr_t;

  // Bits needed to count 0..depth occupied stack entries.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Push writes at the current depth, pop exposes the
// entry just below. Push-when-full and pop-when-empty are silently ignored;
// the owner decides whether those are errors.
module pc_ret_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic [sp_width(DEPTH)-1:0]  depth,
  output logic                        full,
  output logic                        empty
);

  localparam int SPW  = sp_width(DEPTH);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [SPW-1:0] DEPTH_V = SPW'(DEPTH);
  localparam logic [SPW-1:0] ONE     = SPW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [SPW-1:0]   depth_q;
  logic [SPW-1:0]   depth_d;
  logic [IDXW-1:0]  wr_idx;
  logic [IDXW-1:0]  top_idx;
  logic             do_push;
  logic             do_pop;

  // Status flags come straight from the registered depth.
  assign full  = (depth_q == DEPTH_V);
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  // Write slot is the current depth (only used when not full, so it fits);
  // top of stack sits one below it (only meaningful when not empty).
  assign wr_idx  = depth_q[IDXW-1:0];
  assign top_idx = IDXW'(depth_q - ONE);
  assign dout    = mem_q[top_idx];

  // Next-state for storage and depth; push wins if both are requested.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    do_push = push && !full;
    do_pop  = pop && !push && !empty;
    if (do_push) begin
      mem_d[wr_idx] = din;
      depth_d       = depth_q + ONE;
    end else if (do_pop) begin
      depth_d = depth_q - ONE;
    end
  end

  // Register update; stored addresses are not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with PC-relative branch and a hardware return-address
// stack. One command executes per edge in fixed priority order; the PC is
// always visible to the control unit and optionally driven onto the bus.
module pc_stack_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int INC_STEP  = 1,
  parameter int RESET_VEC = 0
) (
  input  logic                        CLK,
  input  logic                        PC_RESET,
  input  logic [WIDTH-1:0]            BUS,
  input  logic                        PC_LOAD,
  input  logic                        PC_BRANCH,
  input  logic                        PC_CALL,
  input  logic                        PC_RET,
  input  logic                        PC_INC,
  input  logic                        PC_BUS,
  output logic [WIDTH-1:0]            PC_TOCPU,
  output logic [WIDTH-1:0]            PC_OUT,
  output logic [sp_width(DEPTH)-1:0]  STK_DEPTH,
  output logic                        STK_FULL,
  output logic                        STK_EMPTY,
  output logic                        STK_ERR
);

  localparam logic [WIDTH-1:0] STEP   = WIDTH'(INC_STEP);
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             err_q;
  logic             err_d;
  logic [2:0]       cmd;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_top;
  logic [WIDTH-1:0] ret_addr;
  logic             stk_full;
  logic             stk_empty;

  // Return address pushed by a call: the instruction after the current one.
  assign ret_addr = pc_q + STEP;

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (CLK),
    .rst   (PC_RESET),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (ret_addr),
    .dout  (stk_top),
    .depth (STK_DEPTH),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Pick the single highest-priority request; the rest are dropped.
  always_comb begin
    cmd = CMD_HOLD;
    if (PC_RESET)       cmd = CMD_RESET;
    else if (PC_LOAD)   cmd = CMD_LOAD;
    else if (PC_BRANCH) cmd = CMD_BRANCH;
    else if (PC_CALL)   cmd = CMD_CALL;
    else if (PC_RET)    cmd = CMD_RET;
    else if (PC_INC)    cmd = CMD_INC;
  end

  // Next PC, error flag and stack requests for the selected command.
  // Branch adds the offset as plain WIDTH-bit addition, which is the same
  // bit pattern as signed addition modulo 2^WIDTH.
  always_comb begin
    pc_d     = pc_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (cmd)
      CMD_RESET: begin
        pc_d  = RST_PC;
        err_d = 1'b0;
      end
      CMD_LOAD:   pc_d = BUS;
      CMD_BRANCH: pc_d = pc_q + BUS;
      CMD_CALL: begin
        if (!stk_full) begin
          stk_push = 1'b1;
          pc_d     = BUS;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_RET: begin
        if (!stk_empty) begin
          stk_pop = 1'b1;
          pc_d    = stk_top;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_INC: pc_d = pc_q + STEP;
      default: ;
    endcase
  end

  // PC and sticky error register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (PC_RESET) begin
      pc_q  <= RST_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign PC_TOCPU  = pc_q;
  assign PC_OUT    = PC_BUS ? pc_q : {WIDTH{1'bz}};
  assign STK_FULL  = stk_full;
  assign STK_EMPTY = stk_empty;
  assign STK_ERR   = err_q;

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter with a hardware return-address stack, for the next-generation CPU datapath.
- Adds PC-relative branch, subroutine call/return, configurable width, step and reset vector, plus stack status flags.
- Drives PC_TOCPU continuously to the control unit and PC_OUT onto the shared tristate BUS when PC_BUS is asserted.

Parameters:
- WIDTH, 16, PC and bus width in bits.
- DEPTH, 8, return-stack entries (>=2).
- INC_STEP, 1, increment added by PC_INC and used for the return address.
- RESET_VEC, 0, PC value after reset.

Ports:
- CLK  input  1  rising-edge clock, single domain.
- PC_RESET  input  1  synchronous, active-high reset.
- BUS  input  WIDTH  absolute target (load/call) or two's-complement offset (branch).
- PC_LOAD  input  1  PC <= BUS.
- PC_BRANCH  input  1  PC <= PC + BUS (signed).
- PC_CALL  input  1  push PC+INC_STEP, PC <= BUS.
- PC_RET  input  1  PC <= popped address.
- PC_INC  input  1  PC <= PC + INC_STEP.
- PC_BUS  input  1  bus-drive enable.
- PC_TOCPU  output  WIDTH  current PC, always driven.
- PC_OUT  output  WIDTH  PC when PC_BUS=1, otherwise high-Z.
- STK_DEPTH  output  $clog2(DEPTH+1)  occupied stack entries.
- STK_FULL  output  1  STK_DEPTH == DEPTH.
- STK_EMPTY  output  1  STK_DEPTH == 0.
- STK_ERR  output  1  sticky overflow/underflow flag.

Behaviour:
- All state updates on the rising edge of CLK.
- Reset is synchronous and active-high. When PC_RESET=1 at an edge:
  - PC = RESET_VEC, STK_DEPTH = 0, STK_ERR = 0.
  - STK_EMPTY = 1, STK_FULL = 0.
  - Stack contents are don't-care.
- Reset applies mid-operation and overrides any concurrent command.
- Command priority per edge (highest first): PC_RESET > PC_LOAD > PC_BRANCH > PC_CALL > PC_RET > PC_INC > hold.
  - Exactly one command executes per edge.
  - Lower-priority requests in the same cycle are discarded, not queued.
- Latency: one cycle. The new PC is visible on PC_TOCPU the cycle after the edge.
- Arithmetic is modulo 2^WIDTH; carries are discarded, no flags.
  - Increment: PC + INC_STEP; 16'hFFFF+1 wraps to 16'h0000.
  - Branch: PC + BUS, BUS read as a signed WIDTH-bit value; wraps in both directions.
- PC_CALL, STK_DEPTH < DEPTH:
  - stack[STK_DEPTH] <= PC+INC_STEP (wrapped).
  - STK_DEPTH++, PC <= BUS.
- PC_CALL, stack full:
  - No push, PC unchanged, STK_ERR <= 1.
- PC_RET, STK_DEPTH > 0:
  - PC <= stack[STK_DEPTH-1], STK_DEPTH--.
- PC_RET, stack empty:
  - PC unchanged, STK_ERR <= 1.
- STK_ERR is sticky; only reset clears it.
- PC_OUT is purely combinational from PC_BUS and PC; high-Z when PC_BUS=0. PC_BUS has no effect on state.
- STK_FULL, STK_EMPTY and STK_DEPTH are registered-state derived and update in the same cycle as the PC.
- The stack is LIFO with no wrap. An entry is read only at index STK_DEPTH-1.

Decomposition:
- Shared package cpu_pkg:
  - Command-priority encoding localparams (CMD_RESET..CMD_HOLD).
  - Function for the stack-pointer width ($clog2(DEPTH+1)).
  - Typedef for the WIDTH-bit address.
- One sub-module: pc_ret_stack (parametrised WIDTH/DEPTH LIFO).
  - Inputs: push, pop, din.
  - Outputs: dout (top entry), depth, full, empty.
  - Ignores push-when-full and pop-when-empty.
  - pc_stack_unit owns priority, PC register, error flag and tristate output.

Test Plan:
- Reset, then 3 cycles PC_INC=1 (INC_STEP=1): PC_TOCPU = 0,1,2,3. PC_BUS=1 gives PC_OUT=3; PC_BUS=0 gives PC_OUT=Z.
- Wrap and branch:
  - PC_LOAD BUS=16'hFFFF, then PC_INC -> PC=16'h0000.
  - PC=16'h0010, PC_BRANCH BUS=16'hFFF8 (-8) -> PC=16'h0008.
  - PC=16'h0008, PC_BRANCH BUS=16'h0004 -> PC=16'h000C.
- Nested calls:
  - At PC=16'h0020, PC_CALL BUS=16'h0100 -> PC=16'h0100, STK_DEPTH=1.
  - PC_CALL BUS=16'h0200 -> PC=16'h0200, STK_DEPTH=2.
  - PC_RET -> PC=16'h0101; PC_RET -> PC=16'h0021; STK_EMPTY=1, STK_ERR=0.
- Overflow/underflow (DEPTH=8):
  - 8 calls -> STK_FULL=1.
  - 9th call -> PC unchanged, STK_DEPTH=8, STK_ERR=1.
  - Reset, then PC_RET on empty stack -> PC=RESET_VEC, STK_ERR=1.
- Priority: PC_LOAD=1, PC_CALL=1, PC_INC=1, BUS=16'h0040 in one cycle -> PC=16'h0040, STK_DEPTH unchanged.
- Reset mid-operation: STK_DEPTH=3, STK_ERR=1; assert PC_RESET together with PC_CALL -> next cycle PC=RESET_VEC, STK_DEPTH=0, STK_ERR=0, STK_EMPTY=1.
